// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronises and de-glitches the device clock, decodes 11-bit frames,
// and assembles 3-byte movement packets into a toggle-flagged 25-bit bus.
module ps2_mouse_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [24:0] ps2_mouse,
    output logic        err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity across the data byte and its parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q;
    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [1:0]    idx_q;
    logic [7:0]    byte0_q, byte1_q;
    logic [TW-1:0] to_cnt_q;
    logic          timeout_s;
    logic [24:0]   mouse_q;
    logic          err_q;

    // The filtered clock only follows the synced pad after FILTER_LEN disagreeing samples in a row
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + {{(FW-1){1'b0}}, 1'b1};
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    assign timeout_s = !fall_q && (to_cnt_q == TW'(TIMEOUT_CYC)) &&
                       ((state_q != ST_IDLE) || (idx_q != 2'd0));

    // Synchronisers, filter, frame FSM, packet assembly and timeout
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            state_q    <= ST_IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            idx_q      <= 2'd0;
            byte0_q    <= 8'h00;
            byte1_q    <= 8'h00;
            to_cnt_q   <= '0;
            mouse_q    <= 25'h0;
            err_q      <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= filt_clk_q & ~filt_clk_d;
            err_q      <= 1'b0;

            if (fall_q) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TW'(TIMEOUT_CYC)) begin
                to_cnt_q <= to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                to_cnt_q <= to_cnt_q;
            end

            if (timeout_s) begin
                state_q <= ST_IDLE;
                idx_q   <= 2'd0;
            end else if (fall_q) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q  <= ST_DATA;
                            bitcnt_q <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_q  <= {dat_s2_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!dat_s2_q || !odd_parity_ok(shift_q, par_q)) begin
                            err_q <= 1'b1;
                            idx_q <= 2'd0;
                        end else begin
                            case (idx_q)
                                2'd0: begin
                                    // Bit 3 of the status byte is always set; use it to resync
                                    if (shift_q[3]) begin
                                        byte0_q <= shift_q;
                                        idx_q   <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    byte1_q <= shift_q;
                                    idx_q   <= 2'd2;
                                end
                                2'd2: begin
                                    idx_q   <= 2'd0;
                                    mouse_q <= {~mouse_q[24], shift_q, byte1_q, byte0_q};
                                end
                                default: idx_q <= 2'd0;
                            endcase
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ps2_mouse = mouse_q;
    assign err       = err_q;

endmodule
